sw_input_ctrl: RTL and testbench
================================

// Module: sw_input_ctrl
// PURPOSE
//  Input conditioning stage that sits directly upstream of picoMIPS, between the raw board switches and
//  the processor SW bus. It synchronises and debounces all 10 switches and drives the clean SW bus.
//  It also detects a debounced SW[8] "read" press and presents it as a one-cycle strobe, with the
//  SW[n-1:0] data latched at that press. This gives picoMIPS one clean capture per physical press.
// PARAMETERS
//  n          8   data bus width; rd_data width, must be <= 8
//  DB_CYCLES  4   consecutive stable cycles required before a clean bit changes (>= 2)
//  CNT_W      4   width of rd_count capture counter
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  reset     in   1      synchronous, active-high; overrides everything
//  sw_raw    in   10     raw asynchronous board switches
//  SW        out  10     debounced switch bus to picoMIPS
//  rd_strobe out  1      one-cycle pulse per accepted SW[8] press
//  rd_data   out  n      SW[n-1:0] latched at the accepted press, held until the next press
//  rd_count  out  CNT_W  accepted-press counter, wraps
//  armed     out  1      1 when the FSM is in ARMED
// BEHAVIOUR
//  Reset, taking effect at the next rising edge:
//   - sync flops, SW, debounce counters, rd_strobe, rd_data and rd_count all clear to 0.
//   - FSM goes to IDLE; armed=0.
//  Synchroniser: per bit, two flops (s1 then s2). s2 lags sw_raw by 2 edges.
//  Debounce, per bit i:
//   - s2[i]==SW[i]: cnt[i] clears to 0.
//   - s2[i]!=SW[i] and cnt[i]<DB_CYCLES-1: cnt[i] increments.
//   - s2[i]!=SW[i] and cnt[i]==DB_CYCLES-1: SW[i] takes s2[i] and cnt[i] clears.
//   - A glitch shorter than DB_CYCLES restarts the count, so SW[i] is unchanged.
//   - Latency from a stable raw edge to SW: 2+DB_CYCLES rising edges (6 at defaults).
//  FSM, registered, one transition per edge:
//   - IDLE -> ARMED when SW[9]==1, SW[8]==0, s2[8]==0 and cnt[8]==0 (SW[8] stably low).
//   - A switch held high through reset therefore never produces a capture until it is released.
//   - ARMED -> CAPTURE when SW[8]==1. On that edge rd_data<=SW[n-1:0] and rd_count<=rd_count+1,
//     wrapping from 2^CNT_W-1 to 0.
//   - CAPTURE -> HELD unconditionally. rd_strobe is 1 only while the FSM is in CAPTURE, so it is
//     exactly one cycle wide and appears 1 edge after SW[8] rises.
//   - HELD -> ARMED when SW[8]==0.
//   - Any state -> IDLE when SW[9]==0. This has priority over all other transitions.
//     - A CAPTURE pending on the same edge is dropped: no latch, no count.
//     - If the FSM is already in CAPTURE, the strobe still finishes its single cycle.
//  Outputs:
//   - SW is a registered output, updated only by the debounce logic.
//   - rd_data is unchanged outside the CAPTURE-entry edge.
//  Reset asserted mid-debounce or mid-capture: everything returns to its reset values with no
//  partial strobe.
// TESTING
//  1 Assert reset for 3 edges with sw_raw=10'h3FF -> SW=0, rd_strobe=0, rd_data=0, rd_count=0,
//    armed=0 immediately after the first reset edge.
//  2 Set sw_raw=10'b1000000000 and let it settle; then set sw_raw=10'b1100000110 ->
//    SW=10'b1100000110 after edge 6; rd_strobe=1 for exactly the cycle after edge 7;
//    rd_data=8'h06; rd_count=1.
//  3 Bounce: with ARMED, toggle sw_raw[8] every 2 cycles for 12 cycles, then hold it at 0 ->
//    SW[8] stays 0, no rd_strobe, rd_count unchanged.
//  4 Hold sw_raw=10'b1100010100 through reset and release reset -> no strobe. Then drop bit 8 and
//    raise it again -> exactly one strobe, rd_data=8'h14.
//  5 In HELD, drop sw_raw[9] -> FSM goes to IDLE (armed=0). Raise SW[8] with SW[9]==0 -> no strobe.
//    Restore SW[9] with SW[8] low -> ARMED.
//  6 Make 2^CNT_W+1 clean presses -> rd_count goes 15 -> 0 -> 1, and each press gives exactly one strobe.

Source files
------------

// File: rtl/sw_input_ctrl.sv
// -----------------------------------------------------------------------------
// sw_input_ctrl
//
// Input conditioning stage between the raw board switches and the picoMIPS SW
// bus. Every switch is passed through a two-flop synchroniser and a per-bit
// debouncer. The clean bus drives SW. A small FSM turns each debounced SW[8]
// press into a single-cycle read strobe. It latches SW[n-1:0] at that press and
// counts accepted presses. SW[9] acts as an enable: while it is low, no press
// is accepted.
//
// Parameters
//   n          data width of rd_data (must be <= 8)
//   DB_CYCLES  consecutive disagreeing samples needed to move a clean bit (>= 2)
//   CNT_W      width of the accepted-press counter
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high; overrides everything
//   sw_raw     raw asynchronous board switches
//   SW         debounced switch bus (registered)
//   rd_strobe  one-cycle pulse per accepted SW[8] press
//   rd_data    SW[n-1:0] captured at the accepted press, held until the next one
//   rd_count   accepted-press counter; wraps to 0 after its maximum value
//   armed      1 while the FSM waits in ARMED for a press
// -----------------------------------------------------------------------------
module sw_input_ctrl #(
  parameter int n         = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       sw_raw,
  output logic [9:0]       SW,
  output logic             rd_strobe,
  output logic [n-1:0]     rd_data,
  output logic [CNT_W-1:0] rd_count,
  output logic             armed
);

  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_HELD
  } state_t;

  logic [9:0]       r_s1;
  logic [9:0]       r_s2;
  logic [9:0]       r_sw;
  logic [DB_W-1:0]  r_cnt [10];

  state_t           r_state;
  logic             r_strobe;
  logic [n-1:0]     r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_armed;

  state_t           w_next;
  logic             w_arm_ok;
  logic             w_take;

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer. A clean bit follows the synchronised bit only
  // after DB_CYCLES consecutive edges of disagreement. Any agreement in between
  // clears the count, so short glitches never reach SW.
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make every register here sample pre-edge
  // values, so r_s2 sees last cycle's r_s1 and the counters see last cycle's SW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_sw <= '0;
      for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 10; i++) begin
        if (r_s2[i] == r_sw[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_sw[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Arm only when SW[8] is stably low. The clean bit, the synchronised bit and
  // its counter must all agree. A switch held high through reset therefore has
  // to be released before a press can be accepted.
  assign w_arm_ok = r_sw[9] & ~r_sw[8] & ~r_s2[8] & (r_cnt[8] == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic. Dropping SW[9] wins over every other transition.
  // ---------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (!r_sw[9]) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    if (w_arm_ok) w_next = ST_ARMED;
        ST_ARMED:   if (r_sw[8])  w_next = ST_CAPTURE;
        ST_CAPTURE:               w_next = ST_HELD;
        ST_HELD:    if (!r_sw[8]) w_next = ST_ARMED;
        default:                  w_next = ST_IDLE;
      endcase
    end
  end

  // Data and count update only on the edge that actually enters CAPTURE. A
  // press that coincides with SW[9] dropping is therefore lost entirely.
  assign w_take = (r_state == ST_ARMED) && (w_next == ST_CAPTURE);

  // Registered FSM outputs are derived from the next state, so they line up
  // with the state register instead of trailing it by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_strobe <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strobe <= (w_next == ST_CAPTURE);
      r_armed  <= (w_next == ST_ARMED);
      if (w_take) begin
        r_data  <= r_sw[n-1:0];
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign SW        = r_sw;
  assign rd_strobe = r_strobe;
  assign rd_data   = r_data;
  assign rd_count  = r_count;
  assign armed     = r_armed;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_input_ctrl
//
// Self-checking bench for sw_input_ctrl at its default parameters.
//
// The bench runs in three parts:
//   - A cycle-by-cycle table covering reset and the first clean capture.
//   - Hand-written sequences for bounce, switches held through reset, the
//     SW[9] enable, and counter wrap.
//   - Randomised stimulus compared against a reference model.
//
// In the model, a clean bit flips once its last DB_CYCLES synchronised samples
// all disagree with it. The press logic is written as a small transition
// function over named modes.
// -----------------------------------------------------------------------------
module tb_sw_input_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] SW;
  logic       rd_strobe;
  logic [7:0] rd_data;
  logic [3:0] rd_count;
  logic       armed;

  int n_tests = 0;
  int n_fail  = 0;

  sw_input_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .SW        (SW),
    .rd_strobe (rd_strobe),
    .rd_data   (rd_data),
    .rd_count  (rd_count),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_WAIT_PRESS = 1, M_PULSE = 2, M_WAIT_RELEASE = 3;

  logic [9:0] m_s1 = '0, m_s2 = '0, m_sw = '0;
  logic [9:0] m_hist [DB-1];  // previous synchronised samples, [0] = newest
  int         m_mode = M_IDLE;
  logic       m_strobe = 1'b0, m_armed = 1'b0;
  logic [7:0] m_data = '0;
  logic [3:0] m_count = '0;

  always @(posedge clk) begin : model
    logic [9:0] nsw;
    logic       dis;
    int         nm;
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_sw <= '0;
      for (int k = 0; k < DB-1; k++) m_hist[k] <= '0;
      m_mode <= M_IDLE; m_strobe <= 1'b0; m_armed <= 1'b0;
      m_data <= '0; m_count <= '0;
    end else begin
      nsw = m_sw;
      for (int b = 0; b < 10; b++) begin
        dis = (m_s2[b] != m_sw[b]);
        for (int k = 0; k < DB-1; k++) dis = dis && (m_hist[k][b] != m_sw[b]);
        if (dis) nsw[b] = m_s2[b];
      end
      nm = m_mode;
      if (!m_sw[9]) nm = M_IDLE;
      else if (m_mode == M_IDLE) begin
        if (!m_sw[8] && !m_s2[8] && !m_hist[0][8]) nm = M_WAIT_PRESS;
      end else if (m_mode == M_WAIT_PRESS) begin
        if (m_sw[8]) nm = M_PULSE;
      end else if (m_mode == M_PULSE) nm = M_WAIT_RELEASE;
      else if (!m_sw[8]) nm = M_WAIT_PRESS;
      if (m_mode == M_WAIT_PRESS && nm == M_PULSE) begin
        m_data  <= m_sw[7:0];
        m_count <= m_count + 4'd1;
      end
      m_hist[0] <= m_s2;
      for (int k = 1; k < DB-1; k++) m_hist[k] <= m_hist[k-1];
      m_s1 <= sw_raw; m_s2 <= m_s1; m_sw <= nsw;
      m_mode <= nm;
      m_strobe <= (nm == M_PULSE);
      m_armed  <= (nm == M_WAIT_PRESS);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a number of cycles, recording strobes and whether armed / SW[8] ever rose.
  task automatic run(input int cycles, output int strobes, output int arm_seen, output int sw8_seen);
    strobes = 0; arm_seen = 0; sw8_seen = 0;
    repeat (cycles) begin
      tick();
      if (rd_strobe) strobes++;
      if (armed)     arm_seen++;
      if (SW[8])     sw8_seen++;
    end
  endtask

  task automatic wait_armed(input string name, input int max);
    int k = 0;
    while (armed !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    check(name, 32'(armed), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic [9:0] raw;
    int         n;
    logic [9:0] sw;
    logic       stb;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       arm;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int st, ar, s8;
    logic [7:0] d;
    reset  = 1'b1;
    sw_raw = 10'h3FF;

    // Reset, then enable only, then a press with data 0x06. The edge count
    // runs from the first edge of each row.
    tbl[0] = '{1'b1, 10'h3FF, 3, 10'h000, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 10'h200, 5, 10'h000, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 10'h200, 1, 10'h200, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 10'h200, 2, 10'h200, 1'b0, 8'h00, 4'd0, 1'b1};
    tbl[4] = '{1'b0, 10'h306, 5, 10'h200, 1'b0, 8'h00, 4'd0, 1'b1};
    tbl[5] = '{1'b0, 10'h306, 1, 10'h306, 1'b0, 8'h00, 4'd0, 1'b1};
    tbl[6] = '{1'b0, 10'h306, 1, 10'h306, 1'b1, 8'h06, 4'd1, 1'b0};
    tbl[7] = '{1'b0, 10'h306, 2, 10'h306, 1'b0, 8'h06, 4'd1, 1'b0};

    for (int r = 0; r < 8; r++) begin
      reset  = tbl[r].rst;
      sw_raw = tbl[r].raw;
      for (int c = 0; c < tbl[r].n; c++) begin
        tick();
        check($sformatf("tbl%0d_c%0d", r, c),
              32'({SW, rd_strobe, rd_data, rd_count, armed}),
              32'({tbl[r].sw, tbl[r].stb, tbl[r].data, tbl[r].cnt, tbl[r].arm}));
      end
    end

    // Bounce on SW[8] while armed: every pulse is shorter than the debounce window.
    sw_raw = 10'h206;
    wait_armed("bounce_arm", 12);
    for (int k = 0; k < 6; k++) begin
      sw_raw[8] = (k % 2 == 0);
      run(2, st, ar, s8);
      check($sformatf("bounce_sw8_%0d", k), 32'(s8), 32'd0);
      check($sformatf("bounce_stb_%0d", k), 32'(st), 32'd0);
    end
    sw_raw[8] = 1'b0;
    run(10, st, ar, s8);
    check("bounce_tail_stb", 32'(st), 32'd0);
    check("bounce_count", 32'(rd_count), 32'd1);
    check("bounce_data", 32'(rd_data), 32'h06);
    check("bounce_armed", 32'(armed), 32'd1);

    // Switches held high through reset: no capture until SW[8] is released.
    reset  = 1'b1;
    sw_raw = 10'h314;
    run(3, st, ar, s8);
    check("hold_rst_count", 32'(rd_count), 32'd0);
    reset = 1'b0;
    run(15, st, ar, s8);
    check("hold_no_stb", 32'(st), 32'd0);
    check("hold_no_arm", 32'(ar), 32'd0);
    check("hold_sw", 32'(SW), 32'h314);
    sw_raw = 10'h214;
    wait_armed("hold_rel_arm", 12);
    sw_raw = 10'h314;
    run(12, st, ar, s8);
    check("hold_one_stb", 32'(st), 32'd1);
    check("hold_data", 32'(rd_data), 32'h14);
    check("hold_count", 32'(rd_count), 32'd1);

    // SW[9] low forces IDLE and blocks presses; restoring it with SW[8] low re-arms.
    sw_raw = 10'h114;
    run(10, st, ar, s8);
    check("en_off_armed", 32'(armed), 32'd0);
    sw_raw = 10'h014;
    run(10, st, ar, s8);
    sw_raw = 10'h114;
    run(12, st, ar, s8);
    check("en_off_no_stb", 32'(st), 32'd0);
    check("en_off_no_arm", 32'(ar), 32'd0);
    check("en_off_count", 32'(rd_count), 32'd1);
    sw_raw = 10'h014;
    run(10, st, ar, s8);
    sw_raw = 10'h214;
    wait_armed("en_on_arm", 12);

    // 17 clean presses: the counter wraps through 15 -> 0 -> 1 -> 2.
    for (int p = 0; p < 17; p++) begin
      d = 8'($urandom);
      sw_raw = {2'b11, d};
      run(12, st, ar, s8);
      check($sformatf("wrap_stb_%0d", p), 32'(st), 32'd1);
      check($sformatf("wrap_data_%0d", p), 32'(rd_data), 32'(d));
      check($sformatf("wrap_cnt_%0d", p), 32'(rd_count), 32'((p + 2) % 16));
      sw_raw = {2'b10, d};
      wait_armed($sformatf("wrap_rearm_%0d", p), 12);
    end

    // Randomised stimulus against the model: held values of varied length,
    // rare enable drops and rare resets.
    for (int s = 0; s < 120; s++) begin
      logic [9:0] v;
      int hold;
      v    = 10'($urandom);
      v[9] = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 10);
      reset  = ($urandom_range(0, 29) == 0);
      sw_raw = v;
      for (int c = 0; c < hold; c++) begin
        tick();
        check("rand", 32'({SW, rd_strobe, rd_data, rd_count, armed}),
              32'({m_sw, m_strobe, m_data, m_count, m_armed}));
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
